song_sequencer: RTL

Controller that sequences the note player through a stored song.
- Fetches (note, duration) entries from a synchronous song ROM.
- Issues one-cycle load pulses to the note player and waits for the player's note-done level before advancing.
- Gates the player's play enable.
- Sits between user controls (play/pause, song select) and the note player, in the same clock domain as the beat generator.

---
 rtl/song_sequencer_pkg.sv | 32 +++
 rtl/song_sequencer_dffre.sv | 20 ++
 rtl/song_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared song-sequencer definitions: field widths, the end-of-song duration marker and FSM state codes.
// ROM word layout is {note, duration}; a zero duration terminates a song.
package song_sequencer_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int WORD_W = NOTE_W + DUR_W;

    localparam logic [DUR_W-1:0] END_DURATION = '0;
    localparam logic [IDX_W-1:0] IDX_LAST     = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_WAIT_NOTE = 3'd3,
        S_END       = 3'd4
    } state_t;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/song_sequencer_dffre.sv
// Generic register with synchronous active-high reset and load enable; 1-cycle latency, no backpressure.
module song_sequencer_dffre #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Walks a song ROM, pulsing load_note per entry and waiting on the player's note_done; 3 cycles overhead per note.
// play low pauses in WAIT_NOTE only. Macro LOOP_SONG_EN: END restarts the same song while play is high.
module song_sequencer
    import song_sequencer_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              play_i,
    input  logic [SONG_W-1:0] song_sel_i,
    input  logic              note_done_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [WORD_W-1:0] rom_data_i,
    output logic [NOTE_W-1:0] note_out_o,
    output logic [DUR_W-1:0]  duration_out_o,
    output logic              load_note_o,
    output logic              player_en_o,
    output logic              busy_o,
    output logic              song_done_o,
    output logic [IDX_W-1:0]  note_index_o
);

    state_t              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    dur_q;
    logic                load_q;
    logic                done_q;

    logic [SONG_W-1:0]   song_q;
    logic [SONG_W-1:0]   song_d;
    logic                song_en;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                idx_en;

    logic                start;
    logic                note_fin;
    logic                advance;
    logic                restart;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_note = word_note(rom_data_i);
    assign rom_dur  = word_dur(rom_data_i);

    // load_q marks the first WAIT_NOTE cycle, where note_done still reflects the previous note.
    always_comb begin
        start    = (state_q == S_IDLE) && play_i;
        note_fin = (state_q == S_WAIT_NOTE) && play_i && !load_q && note_done_i;
        advance  = note_fin && (idx_q != IDX_LAST);
`ifdef LOOP_SONG_EN
        restart  = (state_q == S_END) && play_i;
`else
        restart  = 1'b0;
`endif
        song_d   = song_sel_i;
        song_en  = start;
        idx_en   = start || advance || restart;
        idx_d    = advance ? idx_q + 1'b1 : '0;
    end

    song_sequencer_dffre #(.W(SONG_W)) u_song_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (song_en),
        .d_i     (song_d),
        .q_o     (song_q)
    );

    song_sequencer_dffre #(.W(IDX_W)) u_idx_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (idx_en),
        .d_i     (idx_d),
        .q_o     (idx_q)
    );

    // rom_addr is loaded on entry to FETCH so the ROM word lands during DECODE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FETCH;
                        rom_addr_q <= {song_d, idx_d};
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (rom_dur == END_DURATION) begin
                        state_q <= S_END;
                        done_q  <= 1'b1;
                    end else begin
                        note_q  <= rom_note;
                        dur_q   <= rom_dur;
                        load_q  <= 1'b1;
                        state_q <= S_WAIT_NOTE;
                    end
                end
                S_WAIT_NOTE: begin
                    if (note_fin) begin
                        if (advance) begin
                            state_q    <= S_FETCH;
                            rom_addr_q <= {song_q, idx_d};
                        end else begin
                            state_q <= S_END;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    if (restart) begin
                        state_q    <= S_FETCH;
                        rom_addr_q <= {song_q, idx_d};
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign note_out_o     = note_q;
    assign duration_out_o = dur_q;
    assign load_note_o    = load_q;
    assign song_done_o    = done_q;
    assign note_index_o   = idx_q;
    assign busy_o         = (state_q != S_IDLE);
    // Gating is a direct level so a pause stops the player's beat count in the same cycle.
    assign player_en_o    = (state_q == S_WAIT_NOTE) && play_i;

endmodule
